isp_ae_hist_reader: RTL and testbench
=====================================

# isp_ae_hist_reader

Sweeps the four Bayer-channel auto-exposure histograms out of the AE statistics block after every frame and reduces them to exposure metrics. For each frame it produces a pixel count, a bin-weighted luminance sum, an over-exposed count and an under-exposed count. It sits beside the AE statistics block:
- its `in_done` is driven from that block's frame-done pulse;
- its `hist_out`/`hist_addr` drive that block's histogram read port;
- that block's `hist_data` returns here.

Results feed the AE control loop (firmware register bank or hardware exposure controller).

## Interface
Parameters:
- `HIST_BITS`, 8, bin index width; one channel has 2^HIST_BITS bins.
- `OUT_BITS`, 32, bin count width and width of the count results.
- `RD_LAT`, 1, cycles from `hist_out`/`hist_addr` presented to matching `hist_data` valid (1..4).

Ports:
- `pclk`  in  1  single clock; the statistics block's `hist_clk` is tied to `pclk`.
- `rst`  in  1  synchronous, active-high reset.
- `in_done`  in  1  one-cycle pulse: the frame's histograms are complete.
- `thr_lo`  in  HIST_BITS  bins <= thr_lo count as under-exposed.
- `thr_hi`  in  HIST_BITS  bins >= thr_hi count as over-exposed.
- `hist_out`  out  1  read strobe.
- `hist_addr`  out  HIST_BITS+2  {channel[1:0], bin}; 00 R, 01 Gr, 10 Gb, 11 B.
- `hist_data`  in  OUT_BITS  bin count returned RD_LAT cycles after the strobe.
- `busy`  out  1  sweep in progress.
- `res_valid`  out  1  one-cycle pulse; results updated.
- `res_cnt`  out  OUT_BITS  sum of all bins read.
- `res_sum`  out  OUT_BITS+HIST_BITS  sum of bin_index*count.
- `res_under`  out  OUT_BITS  sum of counts with bin <= thr_lo.
- `res_over`  out  OUT_BITS  sum of counts with bin >= thr_hi.
- `ovf`  out  1  one-cycle pulse: `in_done` arrived while busy and was ignored.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE to READ on `in_done`. Entering READ clears the accumulators and sets the address counter to the first swept address.
- READ:
  - `hist_out`=1 every cycle.
  - `hist_addr` increments by 1 per cycle over N addresses: channels in ascending order, bins 0..2^HIST_BITS-1 within each channel.
  - After the last address the FSM goes to DRAIN.
- DRAIN: `hist_out`=0 and `hist_addr` holds its last value. Lasts RD_LAT cycles, then the FSM goes to DONE.
- DONE: copies the accumulators to the res_* registers, pulses `res_valid`, returns to IDLE.
- A valid/bin-index shift register of depth RD_LAT tracks the strobe and the address low bits. Each cycle its output is valid, the following update happens on `hist_data`:
  - cnt += data
  - sum += bin*data
  - under += data if bin <= thr_lo
  - over += data if bin >= thr_hi
- Thresholds are sampled on `in_done` and held for the whole sweep.
- All accumulators saturate at their all-ones value and never wrap.
- bin*data is a full HIST_BITS x OUT_BITS product before the add.
- `busy` = (state != IDLE).
- `in_done` while busy: the pulse is ignored, `ovf` pulses the next cycle, and the sweep in progress completes unaffected.
- thr_lo >= thr_hi is legal; a bin can count toward both `res_under` and `res_over`.
- `res_*` hold their values until the next DONE.

## Timing
- Reset values: `hist_out`=0, `hist_addr`=0, `busy`=0, `res_valid`=0, `ovf`=0, all res_*=0, state IDLE, pipeline empty.
- `in_done` sampled high in cycle T: `hist_out` high in cycles T+1..T+N, with addr k in cycle T+1+k.
- Data for addr k is sampled at the end of cycle T+1+k+RD_LAT.
- DRAIN occupies T+N+1..T+N+RD_LAT.
- `res_valid` is high in cycle T+N+RD_LAT+1, with res_* valid that same cycle.
- Earliest accepted restart: `in_done` in the cycle after `res_valid`.
- `rst` mid-sweep:
  - returns to IDLE and clears the pipeline and all outputs next cycle;
  - no `res_valid` is issued;
  - the next `in_done` starts a clean sweep.

## Configuration
- `ISP_AE_HIST_GREEN_ONLY_EN` defined:
  - only channels 01 (Gr) and 10 (Gb) are swept;
  - N = 2*2^HIST_BITS;
  - addresses run from {01,0} to {10,all-ones}.
- Undefined (default):
  - all four channels are swept;
  - N = 4*2^HIST_BITS;
  - addresses run from {00,0} to {11,all-ones}.

## Test plan
- HIST_BITS=8, RD_LAT=1, every bin of every channel = 1; pulse `in_done` -> 1024 consecutive `hist_out` cycles, then `res_valid` exactly 1026 cycles after `in_done`. Results: `res_cnt`=1024, `res_sum`=4*32640=130560, with thr_lo=15/thr_hi=240 `res_under`=64 and `res_over`=64.
- Only R bin 255 = 100, all else 0, thr_hi=255 -> `res_cnt`=100, `res_sum`=25500, `res_over`=100, `res_under`=0.
- R bin 0 = 0xFFFFFFFF and Gr bin 0 = 5, all else 0 -> `res_cnt` saturates at 0xFFFFFFFF.
- `in_done` again 10 cycles into a sweep -> `ovf` pulses once; the single `res_valid` carries the first frame's values; `busy` stays high throughout.
- `rst` at address 300, then `in_done` -> no `res_valid` from the aborted sweep; the second sweep gives the correct full results.
- Build with `ISP_AE_HIST_GREEN_ONLY_EN`, all bins = 1 -> first `hist_addr` = 0x100, last = 0x2FF, `res_cnt`=512; repeat the first scenario with RD_LAT=3 -> `res_valid` 1028 cycles after `in_done` and identical results.

Source files
------------

// File: rtl/isp_ae_hist_reader.sv
// AE histogram reader: sweeps the Bayer-channel histograms after each frame and reduces them to
// count / weighted-sum / under / over metrics. Define ISP_AE_HIST_GREEN_ONLY_EN to sweep only Gr and Gb.
module isp_ae_hist_reader #(
    parameter int HIST_BITS = 8,
    parameter int OUT_BITS  = 32,
    parameter int RD_LAT    = 1
) (
    input  logic                          pclk,
    input  logic                          rst,
    input  logic                          in_done,
    input  logic [HIST_BITS-1:0]          thr_lo,
    input  logic [HIST_BITS-1:0]          thr_hi,
    output logic                          hist_out,
    output logic [HIST_BITS+1:0]          hist_addr,
    input  logic [OUT_BITS-1:0]           hist_data,
    output logic                          busy,
    output logic                          res_valid,
    output logic [OUT_BITS-1:0]           res_cnt,
    output logic [OUT_BITS+HIST_BITS-1:0] res_sum,
    output logic [OUT_BITS-1:0]           res_under,
    output logic [OUT_BITS-1:0]           res_over,
    output logic                          ovf
);

    localparam int AW       = HIST_BITS + 2;
    localparam int SUM_BITS = OUT_BITS + HIST_BITS;

`ifdef ISP_AE_HIST_GREEN_ONLY_EN
    localparam logic [1:0] CH_FIRST = 2'b01;
    localparam logic [1:0] CH_LAST  = 2'b10;
`else
    localparam logic [1:0] CH_FIRST = 2'b00;
    localparam logic [1:0] CH_LAST  = 2'b11;
`endif

    localparam logic [AW-1:0] ADDR_FIRST = {CH_FIRST, {HIST_BITS{1'b0}}};
    localparam logic [AW-1:0] ADDR_LAST  = {CH_LAST, {HIST_BITS{1'b1}}};
    localparam logic [2:0]    DRAIN_LAST = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          addr_q;
    logic [2:0]             drain_q;
    logic [HIST_BITS-1:0]   thr_lo_q, thr_hi_q;
    logic                   ovf_q;

    logic [RD_LAT-1:0]      pipe_v_q, pipe_v_d;
    logic [HIST_BITS-1:0]   pipe_bin_q [RD_LAT];
    logic [HIST_BITS-1:0]   pipe_bin_d [RD_LAT];

    logic [OUT_BITS-1:0]    acc_cnt_q, acc_cnt_d;
    logic [SUM_BITS-1:0]    acc_sum_q, acc_sum_d;
    logic [OUT_BITS-1:0]    acc_under_q, acc_under_d;
    logic [OUT_BITS-1:0]    acc_over_q, acc_over_d;

    logic [OUT_BITS-1:0]    res_cnt_q, res_under_q, res_over_q;
    logic [SUM_BITS-1:0]    res_sum_q;

    logic                   start;
    logic                   last_drain;
    logic                   tap_v;
    logic [HIST_BITS-1:0]   tap_bin;
    logic [SUM_BITS-1:0]    prod;

    function automatic logic [OUT_BITS-1:0] sat_add_cnt(input logic [OUT_BITS-1:0] a,
                                                        input logic [OUT_BITS-1:0] b);
        logic [OUT_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[OUT_BITS] ? {OUT_BITS{1'b1}} : s[OUT_BITS-1:0];
    endfunction

    function automatic logic [SUM_BITS-1:0] sat_add_sum(input logic [SUM_BITS-1:0] a,
                                                        input logic [SUM_BITS-1:0] b);
        logic [SUM_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_BITS] ? {SUM_BITS{1'b1}} : s[SUM_BITS-1:0];
    endfunction

    assign start      = (state_q == S_IDLE) && in_done;
    assign last_drain = (state_q == S_DRAIN) && (drain_q == DRAIN_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_done)                state_d = S_READ;
            S_READ:  if (addr_q == ADDR_LAST)    state_d = S_DRAIN;
            S_DRAIN: if (drain_q == DRAIN_LAST)  state_d = S_DONE;
            S_DONE:                              state_d = S_IDLE;
            default:                             state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        hist_out  = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        case (state_q)
            S_IDLE:  busy      = 1'b0;
            S_READ:  hist_out  = 1'b1;
            S_DONE:  res_valid = 1'b1;
            default: ;
        endcase
    end

    // Address walks the swept range and then parks on the last address through DRAIN.
    always_ff @(posedge pclk) begin
        if (rst) begin
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            if (start) begin
                addr_q <= ADDR_FIRST;
            end else if ((state_q == S_READ) && (addr_q != ADDR_LAST)) begin
                addr_q <= addr_q + 1'b1;
            end
            drain_q <= (state_q == S_DRAIN) ? drain_q + 1'b1 : 3'd0;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            thr_lo_q <= '0;
            thr_hi_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (start) begin
                thr_lo_q <= thr_lo;
                thr_hi_q <= thr_hi;
            end
            ovf_q <= in_done && (state_q != S_IDLE);
        end
    end

    // Strobe/bin delay line, aligned so the tap meets hist_data for the same address.
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
        if (gi == 0) begin : g_head
            assign pipe_v_d[gi]   = hist_out;
            assign pipe_bin_d[gi] = addr_q[HIST_BITS-1:0];
        end else begin : g_tail
            assign pipe_v_d[gi]   = pipe_v_q[gi-1];
            assign pipe_bin_d[gi] = pipe_bin_q[gi-1];
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            pipe_v_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_bin_q[i] <= '0;
            end
        end else begin
            pipe_v_q   <= pipe_v_d;
            pipe_bin_q <= pipe_bin_d;
        end
    end

    assign tap_v   = pipe_v_q[RD_LAT-1];
    assign tap_bin = pipe_bin_q[RD_LAT-1];
    assign prod    = SUM_BITS'(tap_bin) * SUM_BITS'(hist_data);

    always_comb begin
        acc_cnt_d   = acc_cnt_q;
        acc_sum_d   = acc_sum_q;
        acc_under_d = acc_under_q;
        acc_over_d  = acc_over_q;
        if (start) begin
            acc_cnt_d   = '0;
            acc_sum_d   = '0;
            acc_under_d = '0;
            acc_over_d  = '0;
        end else if (tap_v) begin
            acc_cnt_d = sat_add_cnt(acc_cnt_q, hist_data);
            acc_sum_d = sat_add_sum(acc_sum_q, prod);
            if (tap_bin <= thr_lo_q) acc_under_d = sat_add_cnt(acc_under_q, hist_data);
            if (tap_bin >= thr_hi_q) acc_over_d  = sat_add_cnt(acc_over_q, hist_data);
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            acc_cnt_q   <= '0;
            acc_sum_q   <= '0;
            acc_under_q <= '0;
            acc_over_q  <= '0;
        end else begin
            acc_cnt_q   <= acc_cnt_d;
            acc_sum_q   <= acc_sum_d;
            acc_under_q <= acc_under_d;
            acc_over_q  <= acc_over_d;
        end
    end

    // The last sample lands in the final DRAIN cycle; loading from acc_*_d there makes the
    // results registered and valid in the DONE cycle alongside res_valid.
    always_ff @(posedge pclk) begin
        if (rst) begin
            res_cnt_q   <= '0;
            res_sum_q   <= '0;
            res_under_q <= '0;
            res_over_q  <= '0;
        end else if (last_drain) begin
            res_cnt_q   <= acc_cnt_d;
            res_sum_q   <= acc_sum_d;
            res_under_q <= acc_under_d;
            res_over_q  <= acc_over_d;
        end
    end

    assign hist_addr = addr_q;
    assign res_cnt   = res_cnt_q;
    assign res_sum   = res_sum_q;
    assign res_under = res_under_q;
    assign res_over  = res_over_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_isp_ae_hist_reader.sv
// Directed bench for isp_ae_hist_reader: two instances (RD_LAT=1 and RD_LAT=3) share stimulus.
module tb_isp_ae_hist_reader;

`ifdef ISP_AE_HIST_GREEN_ONLY_EN
    localparam int NCH     = 2;
    localparam int A_FIRST = 256;
    localparam int A_LAST  = 767;
`else
    localparam int NCH     = 4;
    localparam int A_FIRST = 0;
    localparam int A_LAST  = 1023;
`endif
    localparam int N = NCH * 256;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_done;
    logic [7:0]  thr_lo, thr_hi;
    logic [31:0] mem [1024];

    wire  [1:0]        h_out, busy, rv, ovf;
    wire  [1:0][9:0]   h_addr;
    wire  [1:0][31:0]  r_cnt, r_under, r_over;
    wire  [1:0][39:0]  r_sum;
    logic [31:0]       hd1;
    logic [31:0]       lat3 [3];
    wire  [31:0]       hd3 = lat3[2];

    always @(posedge clk) begin
        hd1     <= mem[h_addr[0]];
        lat3[0] <= mem[h_addr[1]];
        lat3[1] <= lat3[0];
        lat3[2] <= lat3[1];
    end

    isp_ae_hist_reader #(.HIST_BITS(8), .OUT_BITS(32), .RD_LAT(1)) u_dut1 (
        .pclk(clk), .rst(rst), .in_done(in_done), .thr_lo(thr_lo), .thr_hi(thr_hi),
        .hist_out(h_out[0]), .hist_addr(h_addr[0]), .hist_data(hd1), .busy(busy[0]),
        .res_valid(rv[0]), .res_cnt(r_cnt[0]), .res_sum(r_sum[0]), .res_under(r_under[0]),
        .res_over(r_over[0]), .ovf(ovf[0]));

    isp_ae_hist_reader #(.HIST_BITS(8), .OUT_BITS(32), .RD_LAT(3)) u_dut3 (
        .pclk(clk), .rst(rst), .in_done(in_done), .thr_lo(thr_lo), .thr_hi(thr_hi),
        .hist_out(h_out[1]), .hist_addr(h_addr[1]), .hist_data(hd3), .busy(busy[1]),
        .res_valid(rv[1]), .res_cnt(r_cnt[1]), .res_sum(r_sum[1]), .res_under(r_under[1]),
        .res_over(r_over[1]), .ovf(ovf[1]));

    int total = 0;
    int bad   = 0;

    int          hcnt [2], vcyc [2], vnum [2], ovfn [2], bgap [2];
    logic [9:0]  a_first [2], a_last [2];
    logic [63:0] cap_cnt [2], cap_sum [2], cap_under [2], cap_over [2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 1024; i++) mem[i] = v;
    endtask

    // Pulse in_done, then observe both DUTs for 'window' cycles (cycle c = T+c).
    task automatic sweep(input int extra_done_at, input int rst_at, input int window);
        logic [7:0] lo_keep, hi_keep;
        lo_keep = thr_lo;
        hi_keep = thr_hi;
        for (int d = 0; d < 2; d++) begin
            hcnt[d] = 0; vcyc[d] = -1; vnum[d] = 0; ovfn[d] = 0; bgap[d] = 0;
            a_first[d] = '0; a_last[d] = '0;
            cap_cnt[d] = '0; cap_sum[d] = '0; cap_under[d] = '0; cap_over[d] = '0;
        end
        @(posedge clk); #1;
        in_done = 1'b1;
        @(posedge clk); #1;
        in_done = 1'b0;
        for (int c = 1; c <= window; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (h_out[d]) begin
                    if (hcnt[d] == 0) a_first[d] = h_addr[d];
                    a_last[d] = h_addr[d];
                    hcnt[d]++;
                end
                if (rv[d]) begin
                    vnum[d]++;
                    if (vcyc[d] < 0) begin
                        vcyc[d]      = c;
                        cap_cnt[d]   = 64'(r_cnt[d]);
                        cap_sum[d]   = 64'(r_sum[d]);
                        cap_under[d] = 64'(r_under[d]);
                        cap_over[d]  = 64'(r_over[d]);
                    end
                end
                if (ovf[d]) ovfn[d]++;
                if (!busy[d] && vnum[d] == 0) bgap[d]++;
            end
            // Thresholds must have been captured at in_done; scramble the live inputs.
            if (c == 2) begin
                thr_lo = 8'hFF;
                thr_hi = 8'h00;
            end
            in_done = (c == extra_done_at);
            rst     = (c == rst_at);
            @(posedge clk); #1;
        end
        in_done = 1'b0;
        rst     = 1'b0;
        thr_lo  = lo_keep;
        thr_hi  = hi_keep;
    endtask

    task automatic check_results(input string sc, input logic [63:0] e_cnt, input logic [63:0] e_sum,
                                 input logic [63:0] e_under, input logic [63:0] e_over);
        for (int d = 0; d < 2; d++) begin
            int lat;
            lat = (d == 0) ? 1 : 3;
            check_val($sformatf("%s.L%0d.nvalid", sc, lat), 64'(vnum[d]), 64'd1);
            check_val($sformatf("%s.L%0d.vcyc", sc, lat), 64'(vcyc[d]), 64'(N + lat + 1));
            check_val($sformatf("%s.L%0d.cnt", sc, lat), cap_cnt[d], e_cnt);
            check_val($sformatf("%s.L%0d.sum", sc, lat), cap_sum[d], e_sum);
            check_val($sformatf("%s.L%0d.under", sc, lat), cap_under[d], e_under);
            check_val($sformatf("%s.L%0d.over", sc, lat), cap_over[d], e_over);
        end
    endtask

    initial begin
        rst     = 1'b1;
        in_done = 1'b0;
        thr_lo  = 8'd0;
        thr_hi  = 8'd0;
        fill(32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("rst.L%0d.hist_out", d), 64'(h_out[d]), 64'd0);
            check_val($sformatf("rst.L%0d.hist_addr", d), 64'(h_addr[d]), 64'd0);
            check_val($sformatf("rst.L%0d.busy", d), 64'(busy[d]), 64'd0);
            check_val($sformatf("rst.L%0d.res_valid", d), 64'(rv[d]), 64'd0);
            check_val($sformatf("rst.L%0d.ovf", d), 64'(ovf[d]), 64'd0);
            check_val($sformatf("rst.L%0d.res_cnt", d), 64'(r_cnt[d]), 64'd0);
            check_val($sformatf("rst.L%0d.res_sum", d), 64'(r_sum[d]), 64'd0);
        end

        // All bins = 1, thresholds 15/240.
        fill(32'd1);
        thr_lo = 8'd15;
        thr_hi = 8'd240;
        sweep(0, 0, N + 20);
        check_results("ones", 64'(N), 64'(NCH * 32640), 64'(NCH * 16), 64'(NCH * 16));
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("ones.L%0d.strobes", d), 64'(hcnt[d]), 64'(N));
            check_val($sformatf("ones.L%0d.first_addr", d), 64'(a_first[d]), 64'(A_FIRST));
            check_val($sformatf("ones.L%0d.last_addr", d), 64'(a_last[d]), 64'(A_LAST));
            check_val($sformatf("ones.L%0d.busy_gap", d), 64'(bgap[d]), 64'd0);
            check_val($sformatf("ones.L%0d.ovf", d), 64'(ovfn[d]), 64'd0);
        end
        repeat (5) @(posedge clk);
        #1;
        check_val("hold.L1.res_cnt", 64'(r_cnt[0]), 64'(N));

        // Single bin 255 of the first swept channel = 100; over threshold exactly at 255.
        fill(32'd0);
        mem[A_FIRST + 255] = 32'd100;
        thr_lo = 8'd15;
        thr_hi = 8'd255;
        sweep(0, 0, N + 20);
        check_results("bin255", 64'd100, 64'd25500, 64'd0, 64'd100);

        // Saturation: 0xFFFFFFFF + 5 in bin 0 of two channels.
        fill(32'd0);
        mem[A_FIRST]       = 32'hFFFF_FFFF;
        mem[A_FIRST + 256] = 32'd5;
        thr_lo = 8'd15;
        thr_hi = 8'd240;
        sweep(0, 0, N + 20);
        check_results("sat", 64'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFF, 64'd0);

        // Inverted thresholds: bins 0..200 under, 100..255 over.
        fill(32'd1);
        thr_lo = 8'd200;
        thr_hi = 8'd100;
        sweep(0, 0, N + 20);
        check_results("inv", 64'(N), 64'(NCH * 32640), 64'(NCH * 201), 64'(NCH * 156));

        // Second in_done 10 cycles into the sweep.
        thr_lo = 8'd15;
        thr_hi = 8'd240;
        sweep(10, 0, N + 60);
        check_results("ovf", 64'(N), 64'(NCH * 32640), 64'(NCH * 16), 64'(NCH * 16));
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("ovf.L%0d.pulses", d), 64'(ovfn[d]), 64'd1);
            check_val($sformatf("ovf.L%0d.busy_gap", d), 64'(bgap[d]), 64'd0);
        end

        // Reset while address 300 is on the bus, then a clean sweep.
        sweep(0, 301, N + 20);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("abort.L%0d.nvalid", d), 64'(vnum[d]), 64'd0);
            check_val($sformatf("abort.L%0d.strobes", d), 64'(hcnt[d]), 64'd301);
            check_val($sformatf("abort.L%0d.res_cnt", d), 64'(r_cnt[d]), 64'd0);
            check_val($sformatf("abort.L%0d.busy", d), 64'(busy[d]), 64'd0);
        end
        sweep(0, 0, N + 20);
        check_results("restart", 64'(N), 64'(NCH * 32640), 64'(NCH * 16), 64'(NCH * 16));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
